// File: rtl/tpu_ctrl_if.sv
// Host access bus for tpu_ctrl: one single-cycle access per acc_vld strobe.
interface tpu_ctrl_if #(
    parameter int ADDRW = 16
);
    logic             acc_vld;
    logic             r_w;
    logic [ADDRW-1:0] addr;

    modport master (output acc_vld, output r_w, output addr);
    modport slave  (input  acc_vld, input  r_w, input  addr);
endinterface

// File: rtl/tpu_ctrl.sv
// Host-bus decoder and matrix-multiply run sequencer for the TPU top level.
// Optional macro TPU_CTRL_PERF_EN adds perf_cnt_o / drop_cnt_o counters.
module tpu_ctrl #(
    parameter  int DIM   = 8,
    parameter  int ADDRW = 16,
    localparam int CNTW  = $clog2(3*DIM),
    localparam int RW    = $clog2(DIM)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    tpu_ctrl_if.slave     host,
    output logic          a_wr_en_o,
    output logic [RW-1:0] a_row_o,
    output logic          b_wr_en_o,
    output logic [RW-1:0] b_row_o,
    output logic          c_wr_en_o,
    output logic          c_rd_en_o,
    output logic [RW-1:0] c_row_o,
    output logic          c_half_o,
    output logic          mem_en_o,
    output logic          sys_en_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
`ifdef TPU_CTRL_PERF_EN
    ,
    output logic [31:0]   perf_cnt_o,
    output logic [15:0]   drop_cnt_o
`endif
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [ADDRW-1:0] A_BASE = ADDRW'(32'h0100);
    localparam logic [ADDRW-1:0] A_LIM  = ADDRW'(32'h0100 + 8*DIM);
    localparam logic [ADDRW-1:0] B_BASE = ADDRW'(32'h0200);
    localparam logic [ADDRW-1:0] B_LIM  = ADDRW'(32'h0200 + 8*DIM);
    localparam logic [ADDRW-1:0] C_BASE = ADDRW'(32'h0300);
    localparam logic [ADDRW-1:0] C_LIM  = ADDRW'(32'h0300 + 16*DIM);
    localparam logic [ADDRW-1:0] S_ADDR = ADDRW'(32'h0400);
    localparam logic [CNTW-1:0]  LAST   = CNTW'(3*DIM-3);

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            a_wr_en_q, a_wr_en_d, b_wr_en_q, b_wr_en_d;
    logic            c_wr_en_q, c_wr_en_d, c_rd_en_q, c_rd_en_d;
    logic [RW-1:0]   a_row_q, a_row_d, b_row_q, b_row_d, c_row_q, c_row_d;
    logic            c_half_q, c_half_d;
    logic            done_q, done_d, err_q, err_d;
    logic            start, drop;
    logic            in_a, in_b, in_c, is_start;

    assign in_a     = (host.addr >= A_BASE) && (host.addr < A_LIM);
    assign in_b     = (host.addr >= B_BASE) && (host.addr < B_LIM);
    assign in_c     = (host.addr >= C_BASE) && (host.addr < C_LIM);
    assign is_start = host.addr[ADDRW-1:3] == S_ADDR[ADDRW-1:3];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_wr_en_d = 1'b0;
        b_wr_en_d = 1'b0;
        c_wr_en_d = 1'b0;
        c_rd_en_d = 1'b0;
        a_row_d   = a_row_q;
        b_row_d   = b_row_q;
        c_row_d   = c_row_q;
        c_half_d  = c_half_q;
        done_d    = 1'b0;
        err_d     = err_q;
        start     = 1'b0;
        drop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (host.acc_vld) begin
                    if (in_a) begin
                        if (host.r_w) begin
                            a_wr_en_d = 1'b1;
                            a_row_d   = RW'((host.addr - A_BASE) >> 3);
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (in_b) begin
                        if (host.r_w) begin
                            b_wr_en_d = 1'b1;
                            b_row_d   = RW'((host.addr - B_BASE) >> 3);
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (in_c) begin
                        c_wr_en_d = host.r_w;
                        c_rd_en_d = ~host.r_w;
                        c_row_d   = RW'((host.addr - C_BASE) >> 4);
                        c_half_d  = host.addr[3];
                    end else if (is_start && host.r_w) begin
                        start   = 1'b1;
                        state_d = RUN;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // Every access during a run is dropped, including a repeated start.
                if (host.acc_vld) begin
                    err_d = 1'b1;
                    drop  = 1'b1;
                end
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_wr_en_q <= 1'b0;
            b_wr_en_q <= 1'b0;
            c_wr_en_q <= 1'b0;
            c_rd_en_q <= 1'b0;
            a_row_q   <= '0;
            b_row_q   <= '0;
            c_row_q   <= '0;
            c_half_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_wr_en_q <= a_wr_en_d;
            b_wr_en_q <= b_wr_en_d;
            c_wr_en_q <= c_wr_en_d;
            c_rd_en_q <= c_rd_en_d;
            a_row_q   <= a_row_d;
            b_row_q   <= b_row_d;
            c_row_q   <= c_row_d;
            c_half_q  <= c_half_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign a_wr_en_o = a_wr_en_q;
    assign a_row_o   = a_row_q;
    assign b_wr_en_o = b_wr_en_q;
    assign b_row_o   = b_row_q;
    assign c_wr_en_o = c_wr_en_q;
    assign c_rd_en_o = c_rd_en_q;
    assign c_row_o   = c_row_q;
    assign c_half_o  = c_half_q;
    assign busy_o    = (state_q == RUN);
    assign mem_en_o  = (state_q == RUN);
    assign sys_en_o  = (state_q == RUN);
    assign done_o    = done_q;
    assign err_o     = err_q;

`ifdef TPU_CTRL_PERF_EN
    logic [31:0] perf_q;
    logic [15:0] drop_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_q <= '0;
            drop_q <= '0;
        end else begin
            if (start)
                perf_q <= '0;
            else if (state_q == RUN && perf_q != '1)
                perf_q <= perf_q + 1'b1;
            if (drop && drop_q != '1)
                drop_q <= drop_q + 1'b1;
        end
    end

    assign perf_cnt_o = perf_q;
    assign drop_cnt_o = drop_q;
`endif
endmodule

// File: tb/tb_tpu_ctrl.sv
// Directed self-checking bench for tpu_ctrl (DIM=8): decode, run timing, drops, mid-run reset.
module tb_tpu_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       a_wr_en, b_wr_en, c_wr_en, c_rd_en, c_half;
    logic [2:0] a_row, b_row, c_row;
    logic       mem_en, sys_en, busy, done, err;
    int         pass = 0;
    int         total = 0;
`ifdef TPU_CTRL_PERF_EN
    logic [31:0] perf_cnt;
    logic [15:0] drop_cnt;
`endif

    tpu_ctrl_if #(.ADDRW(16)) bus ();

    tpu_ctrl #(.DIM(8), .ADDRW(16)) dut (
        .clk_i(clk), .rst_i(rst), .host(bus),
        .a_wr_en_o(a_wr_en), .a_row_o(a_row), .b_wr_en_o(b_wr_en), .b_row_o(b_row),
        .c_wr_en_o(c_wr_en), .c_rd_en_o(c_rd_en), .c_row_o(c_row), .c_half_o(c_half),
        .mem_en_o(mem_en), .sys_en_o(sys_en), .busy_o(busy), .done_o(done), .err_o(err)
`ifdef TPU_CTRL_PERF_EN
        , .perf_cnt_o(perf_cnt), .drop_cnt_o(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Present one access for one cycle; returns 1 time unit after the sampling edge.
    task automatic drive(input logic v, input logic rw, input logic [15:0] a);
        bus.acc_vld = v;
        bus.r_w     = rw;
        bus.addr    = a;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [17:0] got;
        bus.acc_vld = 1'b0; bus.r_w = 1'b0; bus.addr = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 16'h0);
            got = {a_wr_en, b_wr_en, c_wr_en, c_rd_en, mem_en, sys_en, busy, done, err,
                   a_row, b_row, c_row};
            total++;
            if (got !== 18'h0 || c_half !== 1'b0)
                $display("FAIL reset_idle cyc%0d: got %h half %b, want 0", i, got, c_half);
            else pass++;
        end
    endtask

    task automatic test_ab_rows();
        for (int r = 0; r < 8; r++) begin
            drive(1'b1, 1'b1, 16'h0100 + 16'(8*r));
            total++;
            if (a_wr_en !== 1'b1 || a_row !== 3'(r) || b_wr_en !== 1'b0 || err !== 1'b0)
                $display("FAIL a_row%0d: en %b row %0d err %b, want en 1 row %0d err 0",
                         r, a_wr_en, a_row, err, r);
            else pass++;
        end
        for (int r = 0; r < 8; r++) begin
            drive(1'b1, 1'b1, 16'h0200 + 16'(8*r) + 16'(r % 8));
            total++;
            if (b_wr_en !== 1'b1 || b_row !== 3'(r) || a_wr_en !== 1'b0)
                $display("FAIL b_row%0d: en %b row %0d a_en %b, want en 1 row %0d a_en 0",
                         r, b_wr_en, b_row, a_wr_en, r);
            else pass++;
        end
        drive(1'b0, 1'b0, 16'h0);
        total++;
        if (a_wr_en !== 1'b0 || b_wr_en !== 1'b0 || a_row !== 3'd7 || b_row !== 3'd7)
            $display("FAIL row_hold: a %b/%0d b %b/%0d, want 0/7 0/7", a_wr_en, a_row, b_wr_en, b_row);
        else pass++;
    endtask

    task automatic test_c_access();
        drive(1'b1, 1'b0, 16'h0318);
        total++;
        if (c_rd_en !== 1'b1 || c_wr_en !== 1'b0 || c_row !== 3'd1 || c_half !== 1'b1 || err !== 1'b0)
            $display("FAIL c_read: rd %b wr %b row %0d half %b err %b, want 1 0 1 1 0",
                     c_rd_en, c_wr_en, c_row, c_half, err);
        else pass++;
        drive(1'b1, 1'b1, 16'h0370);
        total++;
        if (c_wr_en !== 1'b1 || c_rd_en !== 1'b0 || c_row !== 3'd7 || c_half !== 1'b0)
            $display("FAIL c_write: wr %b rd %b row %0d half %b, want 1 0 7 0",
                     c_wr_en, c_rd_en, c_row, c_half);
        else pass++;
    endtask

    task automatic test_run();
        drive(1'b1, 1'b1, 16'h0400);
        for (int k = 1; k <= 22; k++) begin
            total++;
            if (busy !== 1'b1 || mem_en !== 1'b1 || sys_en !== 1'b1 || done !== 1'b0)
                $display("FAIL run_t+%0d: busy %b mem %b sys %b done %b, want 1 1 1 0",
                         k, busy, mem_en, sys_en, done);
            else pass++;
            drive(1'b0, 1'b0, 16'h0);
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || mem_en !== 1'b0 || sys_en !== 1'b0)
            $display("FAIL run_end: done %b busy %b mem %b sys %b, want 1 0 0 0",
                     done, busy, mem_en, sys_en);
        else pass++;
`ifdef TPU_CTRL_PERF_EN
        total++;
        if (perf_cnt !== 32'd22)
            $display("FAIL perf_cnt: got %0d, want 22", perf_cnt);
        else pass++;
`endif
        // Access in the done cycle must be accepted.
        drive(1'b1, 1'b1, 16'h0128);
        total++;
        if (a_wr_en !== 1'b1 || a_row !== 3'd5 || done !== 1'b0 || err !== 1'b0)
            $display("FAIL post_run_access: en %b row %0d done %b err %b, want 1 5 0 0",
                     a_wr_en, a_row, done, err);
        else pass++;
    endtask

    task automatic test_bad_access();
        drive(1'b1, 1'b1, 16'h0500);
        total++;
        if (err !== 1'b1 || {a_wr_en, b_wr_en, c_wr_en, c_rd_en} !== 4'b0)
            $display("FAIL unmapped_write: err %b strobes %b, want 1 0000",
                     err, {a_wr_en, b_wr_en, c_wr_en, c_rd_en});
        else pass++;
        drive(1'b1, 1'b0, 16'h0108);
        total++;
        if (err !== 1'b1 || a_wr_en !== 1'b0 || a_row !== 3'd5)
            $display("FAIL a_read: err %b en %b row %0d, want 1 0 5", err, a_wr_en, a_row);
        else pass++;
    endtask

    task automatic test_drop_in_run();
        drive(1'b1, 1'b1, 16'h0400);
        total++;
        if (err !== 1'b0 || busy !== 1'b1)
            $display("FAIL start_clears_err: err %b busy %b, want 0 1", err, busy);
        else pass++;
        for (int k = 1; k <= 22; k++) begin
            if (k == 3)      drive(1'b1, 1'b1, 16'h0100);
            else if (k == 5) drive(1'b1, 1'b1, 16'h0400);
            else             drive(1'b0, 1'b0, 16'h0);
            if (k == 3) begin
                total++;
                if (a_wr_en !== 1'b0 || err !== 1'b1)
                    $display("FAIL drop_a_write: en %b err %b, want 0 1", a_wr_en, err);
                else pass++;
            end
            if (k == 21) begin
                total++;
                if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b1)
                    $display("FAIL drop_len_t+22: busy %b done %b err %b, want 1 0 1", busy, done, err);
                else pass++;
            end
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL drop_done_t+23: done %b busy %b, want 1 0", done, busy);
        else pass++;
`ifdef TPU_CTRL_PERF_EN
        total++;
        if (drop_cnt !== 16'd2)
            $display("FAIL drop_cnt: got %0d, want 2", drop_cnt);
        else pass++;
`endif
    endtask

    task automatic test_reset_mid_run();
        logic saw_done;
        drive(1'b1, 1'b1, 16'h0400);
        total++;
        if (err !== 1'b0)
            $display("FAIL restart_clears_err: err %b, want 0", err);
        else pass++;
        repeat (9) drive(1'b0, 1'b0, 16'h0);
        rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0);
        rst = 1'b0;
        total++;
        if (busy !== 1'b0 || mem_en !== 1'b0 || sys_en !== 1'b0 || done !== 1'b0)
            $display("FAIL rst_mid_run: busy %b mem %b sys %b done %b, want 0 0 0 0",
                     busy, mem_en, sys_en, done);
        else pass++;
        saw_done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 16'h0);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        total++;
        if (saw_done !== 1'b0)
            $display("FAIL rst_no_done: saw done/busy %b, want 0", saw_done);
        else pass++;
    endtask

    initial begin
        test_reset();
        test_ab_rows();
        test_c_access();
        test_run();
        test_bad_access();
        test_drop_in_run();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
